// File: rtl/pll_reconf_seq.sv
// PLL reconfiguration sequencer: holds NCH downstream domains in reset, drives the
// DRP SADDR/SEN/SRDY handshake, qualifies lock with timeout/retry and staggers releases.
module pll_reconf_seq #(
    parameter int AW        = 8,
    parameter int NCH       = 2,
    parameter int CW        = 12,
    parameter int HOLD_CYC  = 15,
    parameter int STAB_CYC  = 63,
    parameter int LOCK_TO   = 4000,
    parameter int STAGGER   = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic          CLK,
    input  logic          RSTXO,
    input  logic          REQ,
    input  logic [AW-1:0] REQ_ADDR,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic          LOL,
    output logic [AW-1:0] CUR_ADDR,
    output logic [AW-1:0] DRP_SADDR,
    output logic          DRP_SEN,
    input  logic          DRP_SRDY,
    input  logic          PLL_LOCK,
    output logic [NCH-1:0] DOM_RSTX
);
    localparam int IW = $clog2(NCH + 1);

    if (HOLD_CYC >= 2**CW || STAB_CYC >= 2**CW || LOCK_TO >= 2**CW ||
        STAGGER >= 2**CW || MAX_RETRY >= 2**CW) begin : g_bad_param
        $error("pll_reconf_seq: cycle parameter does not fit in CW bits");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ASSERT, S_PROG, S_WAIT_RDY, S_WAIT_LOCK, S_RELEASE
    } state_t;

    state_t        state, nxt;
    logic          lk_m, lk_s;
    logic [CW-1:0] stab, tmo, cnt, retry;
    logic          to_en;
    logic [IW-1:0] idx;

    logic stable, timeout, retry_ok, hold_done, stag_done, rel_last;
    assign stable    = (stab == CW'(STAB_CYC));
    assign timeout   = to_en && (tmo == CW'(LOCK_TO));
    assign retry_ok  = (retry < CW'(MAX_RETRY));
    assign hold_done = (cnt == CW'(HOLD_CYC - 1));
    assign stag_done = (cnt == CW'(STAGGER - 1));
    assign rel_last  = (idx == IW'(NCH));

    // Boot lands in WAIT_LOCK so the first release also waits for a stable lock.
    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) state <= S_WAIT_LOCK;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:      if (REQ) nxt = S_ASSERT;
                         else if (!lk_s && !ERR) nxt = S_WAIT_LOCK;
            S_ASSERT:    if (hold_done) nxt = S_PROG;
            S_PROG:      nxt = S_WAIT_RDY;
            S_WAIT_RDY:  if (DRP_SRDY) nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: if (stable) nxt = S_RELEASE;
                         else if (timeout) nxt = retry_ok ? S_PROG : S_IDLE;
            S_RELEASE:   if (!lk_s) nxt = S_WAIT_LOCK;
                         else if (rel_last) nxt = S_IDLE;
            default:     nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY    = (state != S_IDLE);
        DRP_SEN = (state == S_PROG);
        DONE    = (state == S_RELEASE) && lk_s && rel_last;
    end

    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            lk_m      <= 1'b0;
            lk_s      <= 1'b0;
            stab      <= '0;
            tmo       <= '0;
            cnt       <= '0;
            retry     <= '0;
            to_en     <= 1'b0;
            idx       <= '0;
            ERR       <= 1'b0;
            LOL       <= 1'b0;
            CUR_ADDR  <= '0;
            DRP_SADDR <= '0;
            DOM_RSTX  <= '0;
        end else begin
            lk_m <= PLL_LOCK;
            lk_s <= lk_m;
            if (!lk_s)        stab <= '0;
            else if (!stable) stab <= stab + CW'(1);

            case (state)
                S_IDLE: begin
                    if (REQ) begin
                        DRP_SADDR <= REQ_ADDR;
                        ERR       <= 1'b0;
                        LOL       <= 1'b0;
                        retry     <= '0;
                        cnt       <= '0;
                        DOM_RSTX  <= '0;
                    end else if (!lk_s && !ERR) begin
                        // Lost lock with no reprogramming: wait forever for it to return.
                        LOL      <= 1'b1;
                        DOM_RSTX <= '0;
                        to_en    <= 1'b0;
                    end
                end
                S_ASSERT: cnt <= cnt + CW'(1);
                S_WAIT_RDY: begin
                    if (DRP_SRDY) begin
                        tmo   <= '0;
                        to_en <= 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (to_en) tmo <= tmo + CW'(1);
                    if (stable) begin
                        DOM_RSTX <= NCH'(1);
                        idx      <= IW'(1);
                        cnt      <= '0;
                    end else if (timeout) begin
                        if (retry_ok) retry <= retry + CW'(1);
                        else          ERR   <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!lk_s) begin
                        DOM_RSTX <= '0;
                        LOL      <= 1'b1;
                        to_en    <= 1'b0;
                    end else if (rel_last) begin
                        CUR_ADDR <= DRP_SADDR;
                    end else if (stag_done) begin
                        for (int i = 0; i < NCH; i++)
                            if (idx == IW'(i)) DOM_RSTX[i] <= 1'b1;
                        idx <= idx + IW'(1);
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reconf_seq.sv
// Directed bench for pll_reconf_seq: boot, table of reconfig requests (incl. timeout/ERR),
// then hand sequences for loss-of-lock, REQ collisions and asynchronous reset.
module tb_pll_reconf_seq;
    localparam int AW = 8, NCH = 2;

    logic           CLK = 1'b0, RSTXO = 1'b0, REQ = 1'b0;
    logic [AW-1:0]  REQ_ADDR = '0;
    logic           BUSY, DONE, ERR, LOL, DRP_SEN;
    logic [AW-1:0]  CUR_ADDR, DRP_SADDR;
    logic           DRP_SRDY = 1'b0, PLL_LOCK = 1'b0;
    logic [NCH-1:0] DOM_RSTX;

    pll_reconf_seq dut (
        .CLK(CLK), .RSTXO(RSTXO), .REQ(REQ), .REQ_ADDR(REQ_ADDR),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .LOL(LOL),
        .CUR_ADDR(CUR_ADDR), .DRP_SADDR(DRP_SADDR), .DRP_SEN(DRP_SEN),
        .DRP_SRDY(DRP_SRDY), .PLL_LOCK(PLL_LOCK), .DOM_RSTX(DOM_RSTX)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] addr;
        bit         lock_back;
        int         exp_sen;
        bit         exp_err;
        logic [7:0] exp_cur;
        logic [1:0] exp_dom;
    } vec_t;
    vec_t vecs[4];

    int checks = 0, failures = 0, cyc = 0, srdy_cd = 0, done_cnt = 0;
    int sen_q[$];
    bit drp_auto = 1'b1, lock_back = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // One clock; also models the DRP engine (SRDY 5 cycles after SEN) and
    // the PLL dropping lock while it is being reprogrammed.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (DRP_SEN) sen_q.push_back(cyc);
        if (DONE) done_cnt++;
        if (drp_auto) begin
            DRP_SRDY = 1'b0;
            if (srdy_cd != 0) begin
                srdy_cd--;
                if (srdy_cd == 0) begin
                    DRP_SRDY = 1'b1;
                    if (lock_back) PLL_LOCK = 1'b1;
                end
            end
            if (DRP_SEN) begin
                PLL_LOCK = 1'b0;
                srdy_cd  = 4;
            end
        end
    endtask

    task automatic req(input logic [7:0] a);
        REQ = 1'b1;
        REQ_ADDR = a;
        tick();
        REQ = 1'b0;
    endtask

    task automatic wait_sen(input string nm, output int n);
        n = 0;
        while (!DRP_SEN && n < 100) begin tick(); n++; end
        chk({nm, "_sen_seen"}, int'(DRP_SEN), 1);
    endtask

    task automatic wait_done(input string nm, input int bound);
        int base, n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && !ERR && n < bound) begin tick(); n++; end
        chk({nm, "_finished"}, int'(n < bound), 1);
    endtask

    initial begin
        int c0, r0, n, sb, mg;
        vecs[0] = '{8'h5A, 1'b1, 1, 1'b0, 8'h5A, 2'b11};
        vecs[1] = '{8'hC3, 1'b1, 1, 1'b0, 8'hC3, 2'b11};
        vecs[2] = '{8'h11, 1'b0, 4, 1'b1, 8'hC3, 2'b00};
        vecs[3] = '{8'h7E, 1'b1, 1, 1'b0, 8'h7E, 2'b11};

        repeat (3) tick();
        chk("rst_busy", BUSY, 1);     chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);       chk("rst_lol", LOL, 0);
        chk("rst_cur", CUR_ADDR, 0);  chk("rst_saddr", DRP_SADDR, 0);
        chk("rst_sen", DRP_SEN, 0);   chk("rst_dom", DOM_RSTX, 0);

        // Boot: lock at cycle 20 -> bit 0 at 20+2+63 (+-1), bit 1 eight cycles later.
        RSTXO = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 20) tick();
        PLL_LOCK = 1'b1;
        n = 0;
        while (!DOM_RSTX[0] && n < 300) begin tick(); n++; end
        r0 = cyc;
        chk_rng("boot_rise0_delay", r0 - c0, 84, 86);
        chk("boot_dom_first", DOM_RSTX, 2'b01);
        n = 0;
        while (!DOM_RSTX[1] && n < 50) begin tick(); n++; end
        chk("boot_stagger", cyc - r0, 8);
        tick(); tick();
        chk("boot_done_cnt", done_cnt, 1);
        chk("boot_busy", BUSY, 0);
        chk("boot_cur", CUR_ADDR, 0);
        chk("boot_dom", DOM_RSTX, 2'b11);

        for (int i = 0; i < 4; i++) begin
            lock_back = vecs[i].lock_back;
            sb = sen_q.size();
            req(vecs[i].addr);
            chk($sformatf("v%0d_dom_held", i), DOM_RSTX, 0);
            chk($sformatf("v%0d_busy", i), BUSY, 1);
            chk($sformatf("v%0d_err_clr", i), ERR, 0);
            wait_sen($sformatf("v%0d", i), n);
            chk($sformatf("v%0d_sen_delay", i), n, 15);
            chk($sformatf("v%0d_saddr", i), DRP_SADDR, vecs[i].addr);
            wait_done($sformatf("v%0d", i), 20000);
            tick(); tick();
            chk($sformatf("v%0d_sen_cnt", i), sen_q.size() - sb, vecs[i].exp_sen);
            chk($sformatf("v%0d_err", i), ERR, vecs[i].exp_err);
            chk($sformatf("v%0d_cur", i), CUR_ADDR, vecs[i].exp_cur);
            chk($sformatf("v%0d_dom", i), DOM_RSTX, vecs[i].exp_dom);
            chk($sformatf("v%0d_busy_end", i), BUSY, 0);
            if (vecs[i].exp_sen > 1 && sen_q.size() - sb > 1) begin
                mg = 1 << 30;
                for (int k = sb + 1; k < sen_q.size(); k++)
                    if (sen_q[k] - sen_q[k-1] < mg) mg = sen_q[k] - sen_q[k-1];
                chk_rng($sformatf("v%0d_sen_gap", i), mg, 4000, 4100);
            end
        end

        // Loss of lock in IDLE: holds within 3 cycles, no reprogramming.
        sb = sen_q.size();
        PLL_LOCK = 1'b0;
        repeat (3) tick();
        chk("lol_flag", LOL, 1);
        chk("lol_dom", DOM_RSTX, 0);
        repeat (2) tick();
        PLL_LOCK = 1'b1;
        wait_done("lol", 300);
        tick();
        chk("lol_no_sen", sen_q.size() - sb, 0);
        chk("lol_dom_rel", DOM_RSTX, 2'b11);
        chk("lol_sticky", LOL, 1);
        chk("lol_cur", CUR_ADDR, 8'h7E);

        // REQ during WAIT_RDY is dropped.
        drp_auto = 1'b0;
        req(8'h33);
        chk("coll_lol_clr", LOL, 0);
        wait_sen("coll", n);
        tick();
        req(8'h99);
        chk("coll_saddr", DRP_SADDR, 8'h33);
        chk("coll_busy", BUSY, 1);
        DRP_SRDY = 1'b1;
        tick();
        DRP_SRDY = 1'b0;
        wait_done("coll", 100);
        tick();
        chk("coll_cur", CUR_ADDR, 8'h33);

        // REQ in the same IDLE cycle as a synchronized lock drop: REQ wins.
        drp_auto = 1'b1;
        lock_back = 1'b1;
        PLL_LOCK = 1'b0;
        tick(); tick();
        req(8'h44);
        chk("same_lol", LOL, 0);
        chk("same_busy", BUSY, 1);
        chk("same_saddr", DRP_SADDR, 8'h44);
        wait_done("same", 300);
        tick();
        chk("same_cur", CUR_ADDR, 8'h44);
        chk("same_lol_end", LOL, 0);

        // Asynchronous reset in WAIT_LOCK; the late SRDY must be ignored.
        drp_auto = 1'b0;
        req(8'h66);
        wait_sen("arst", n);
        PLL_LOCK = 1'b0;
        repeat (3) tick();
        DRP_SRDY = 1'b1;
        tick();
        DRP_SRDY = 1'b0;
        repeat (5) tick();
        chk("arst_pre_busy", BUSY, 1);
        chk("arst_pre_saddr", DRP_SADDR, 8'h66);
        #2 RSTXO = 1'b0;
        #1;
        chk("arst_saddr", DRP_SADDR, 0);  chk("arst_cur", CUR_ADDR, 0);
        chk("arst_dom", DOM_RSTX, 0);     chk("arst_busy", BUSY, 1);
        chk("arst_sen", DRP_SEN, 0);      chk("arst_done", DONE, 0);
        tick();
        RSTXO = 1'b1;
        sb = sen_q.size();
        DRP_SRDY = 1'b1;
        tick();
        DRP_SRDY = 1'b0;
        repeat (3) tick();
        chk("late_srdy_saddr", DRP_SADDR, 0);
        chk("late_srdy_sen", sen_q.size() - sb, 0);
        chk("late_srdy_busy", BUSY, 1);
        PLL_LOCK = 1'b1;
        wait_done("arst", 300);
        tick();
        chk("arst_rel_dom", DOM_RSTX, 2'b11);
        chk("arst_rel_cur", CUR_ADDR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pll_reconf_seq.md
Name: pll_reconf_seq

Overview:
- CLK-domain sequencer that owns PLL reconfiguration and downstream reset release for NCH clock domains.
- On a frequency-change request it:
  - holds every domain in reset;
  - drives the DRP engine's SADDR/SEN/SRDY handshake;
  - waits for a stable PLL lock, with timeout and retry;
  - releases the domain resets in staggered order.
- Also supervises lock after boot and after loss-of-lock.
- Successor to the fixed single-config control: parametrised channel count, hold/stagger/timeout lengths, and retry/error reporting.

Parameters:
AW, 8, config code width (DRP SADDR)
NCH, 2, number of downstream domains with reset holds
CW, 12, width of all internal cycle counters
HOLD_CYC, 15, cycles domains stay held before programming starts
STAB_CYC, 63, consecutive synchronized-lock cycles required
LOCK_TO, 4000, cycles allowed from SRDY to stable lock
STAGGER, 8, cycles between successive channel releases
MAX_RETRY, 3, reprogram attempts after a lock timeout before ERR

Ports:
CLK  in  1  control clock
RSTXO  in  1  reset, asynchronous, active-low
REQ  in  1  single-cycle request pulse; accepted only in IDLE
REQ_ADDR  in  AW  config code sampled with accepted REQ
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse when the last channel is released
ERR  out  1  sticky; retries exhausted; cleared only by an accepted REQ or reset
LOL  out  1  sticky loss-of-lock flag; cleared by an accepted REQ or reset
CUR_ADDR  out  AW  last code successfully locked
DRP_SADDR  out  AW  code presented to DRP engine
DRP_SEN  out  1  one-cycle start pulse to DRP engine
DRP_SRDY  in  1  DRP engine completion pulse
PLL_LOCK  in  1  asynchronous PLL lock
DOM_RSTX  out  NCH  active-low per-domain reset holds; bit 0 is released first

Behaviour:
Reset values (RSTXO low):
- BUSY=1, DONE=0, ERR=0, LOL=0, CUR_ADDR=0, DRP_SADDR=0, DRP_SEN=0, DOM_RSTX=all 0.
- State is WAIT_LOCK (boot config), retry count=0.

Lock synchronizer and stability counter:
- PLL_LOCK passes through a 2-flop synchronizer to give lk_s. Never use raw PLL_LOCK.
- stab counter increments while lk_s=1 and clears to 0 when lk_s=0.
- Lock is "stable" when stab reaches STAB_CYC.
- The counter saturates.

States:
- IDLE:
  - DOM_RSTX all 1.
  - REQ=1: latch REQ_ADDR into DRP_SADDR, clear ERR/LOL/retry, go ASSERT. BUSY=1 on the next cycle.
  - lk_s=0 with no REQ: LOL<=1, DOM_RSTX<=0 on the next cycle, go WAIT_LOCK without reprogramming.
  - REQ and lk_s=0 in the same cycle: REQ wins (ASSERT); LOL is not set.
- ASSERT:
  - DOM_RSTX all 0 from the first cycle.
  - Count HOLD_CYC cycles, then go PROG.
- PROG:
  - DRP_SEN=1 for exactly one cycle, then go WAIT_RDY.
- WAIT_RDY:
  - Wait for DRP_SRDY (no timeout).
  - On SRDY: clear the timeout counter, go WAIT_LOCK.
  - An SRDY arriving in any other state is ignored.
- WAIT_LOCK:
  - DOM_RSTX all 0. Timeout counter increments every cycle.
  - Stable lock: go RELEASE.
  - Counter reaches LOCK_TO before stable lock:
    - retry<MAX_RETRY: retry++, go PROG with the same DRP_SADDR.
    - otherwise: ERR<=1, go IDLE with DOM_RSTX held all 0 until the next accepted REQ. ERR state is IDLE with holds asserted.
  - Boot entry, or entry from loss-of-lock: no timeout; wait indefinitely.
- RELEASE:
  - DOM_RSTX[0] rises on the first RELEASE cycle; DOM_RSTX[i] rises i*STAGGER cycles later.
  - After bit NCH-1 rises: DONE=1 for one cycle, CUR_ADDR<=DRP_SADDR (boot keeps 0), go IDLE.
  - lk_s falling during RELEASE: all DOM_RSTX<=0, LOL<=1, go WAIT_LOCK (no timeout); the release restarts from bit 0.

General rules:
- REQ outside IDLE is dropped: no queueing, no flag.
- Counters are CW bits wide; elaboration must fail if any cycle parameter ≥ 2^CW.
- Asserting RSTXO mid-operation aborts immediately to the reset values. A DRP transaction in flight is not cancelled; its SRDY is ignored.
- DOM_RSTX bits are registered outputs, glitch-free. Deassertion is synchronous to CLK; downstream domains must resynchronize.

Test Plan:
- Boot: RSTXO released, PLL_LOCK raised at cycle 20 → DOM_RSTX[0] rises at 20+2+63 (±1), DOM_RSTX[1] 8 cycles later, DONE pulse, CUR_ADDR=0, BUSY falls.
- Reconfig: REQ with REQ_ADDR=0x5A in IDLE → DOM_RSTX=00 next cycle, DRP_SEN one-cycle pulse with SADDR=0x5A after 15 cycles; SRDY plus stable lock → staggered release, CUR_ADDR=0x5A.
- Timeout/retry: lock never returns after SRDY → exactly 4 SEN pulses spaced ≥4000 cycles, then ERR=1, DOM_RSTX stays 00, BUSY=0; a new REQ clears ERR.
- Loss of lock: drop PLL_LOCK for 5 cycles in IDLE → LOL=1, DOM_RSTX=00 within 3 cycles, no SEN pulse, release again after 63 stable cycles.
- Collisions: REQ during WAIT_RDY ignored (SADDR unchanged); REQ and lock-drop in the same IDLE cycle → ASSERT taken, LOL stays 0.
- Reset mid-WAIT_LOCK → all outputs at reset values within 0 cycles (asynchronous); a late SRDY has no effect.
